uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Asynchronous serial receiver (UART RX) for the multi-clock system's RX clock domain.
//   Oversamples RX_IN at Prescale clocks per bit and recovers 8-bit LSB-first frames.
//   Frame format: start(0), 8 data bits, optional parity bit, stop(1).
//   Outputs the byte on P_DATA with a one-cycle data_valid strobe when the frame is
//   error-free.
// PARAMETERS
//   DATA_WIDTH  8  payload bits per frame (fixed at 8 for this revision)
// PORTS
//   CLK         in   1  RX oversampling clock; one clock for the whole block
//   RST         in   1  reset, synchronous, active-high
//   RX_IN       in   1  serial line; idles high; already synchronised to CLK upstream
//   Prescale    in   5  oversampling ratio in clocks per bit; legal values 8 and 16
//   PAR_EN      in   1  1 = frame carries a parity bit after d7
//   PAR_TYP     in   1  0 = even parity, 1 = odd parity
//   P_DATA      out  8  last successfully received byte
//   data_valid  out  1  one-CLK pulse: P_DATA updated with a good frame
// BEHAVIOUR
//   Reset (RST=1 at a CLK edge): FSM=IDLE, all counters=0, P_DATA=8'h00, data_valid=0.
//   Counters:
//   - edge_cnt counts 0..Prescale-1 within a bit; it wraps to 0 at each bit boundary.
//   - bit_cnt indexes the bits of the frame.
//   Sampling:
//   - RX_IN is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
//   - The bit value is the 2-of-3 majority of those samples.
//   - The bit value is stable and used from edge_cnt = P/2+2.
//   Configuration capture: PAR_EN, PAR_TYP and Prescale are latched when the falling
//   start edge is detected. They are held constant for the rest of that frame.
//   FSM states and transitions:
//   - IDLE:   RX_IN=0 -> START; edge_cnt cleared.
//   - START:  at end of bit (edge_cnt=P-1): sampled bit=0 -> DATA.
//             If sampled bit=1 (glitch), go to IDLE; no output.
//   - DATA:   each sampled bit is shifted in LSB first (d0 first).
//             After bit 7 ends: go to PARITY if PAR_EN=1, else STOP.
//   - PARITY: compute expected = ^data XOR PAR_TYP.
//             Set par_err if the sampled bit differs.
//             At bit end -> STOP.
//   - STOP:   set stp_err if the sampled bit=0.
//             At bit end, with no par_err and no stp_err: P_DATA <= shift reg, and
//             data_valid=1 for exactly that one cycle.
//             Next state: RX_IN=0 -> START (back-to-back frame), else IDLE.
//   Error handling:
//   - On any error the frame is discarded: P_DATA is kept and data_valid stays 0.
//   - Error flags are cleared on the next start.
//   P_DATA holds its value between valid frames; data_valid is otherwise 0.
//   Frame length is 1+8+PAR_EN+1 bits = 10 or 11 bits. Latency: data_valid asserts at
//   the last CLK of the stop bit.
//   Back-to-back frames: a start bit immediately following a stop bit is captured
//   with no idle bit in between.
//   Reset mid-frame: the frame is abandoned immediately and the reset values apply.
//   Illegal Prescale values (anything but 8/16) give undefined data but must not lock
//   up the FSM. Every state exits within P*11 clocks.
// STRUCTURE
//   Shared package uart_pkg:
//   - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
//   - PAR_EVEN=1'b0 and PAR_ODD=1'b1.
//   - DATA_WIDTH.
//   One natural sub-module: uart_rx_sampler, holding the edge counter, the 3-sample
//   majority vote and the sampled-bit-valid flag. The FSM, deserializer, parity check
//   and stop check stay in uart_rx.
// TESTING
//   Bit period = Prescale*CLK. All frames are LSB first. Prescale=8 unless noted.
//   1. PAR_EN=1, PAR_TYP=0; send 0,1010_1010,0,1 (byte 8'h55, even parity 0)
//      -> one data_valid pulse, P_DATA=8'h55.
//   2. Immediately back-to-back, send byte 8'h6D with parity bit 0 (wrong for even)
//      -> no data_valid; P_DATA stays 8'h55.
//   3. PAR_EN=0 and the line idle; send 0,1010_1010,1 (10-bit frame)
//      -> data_valid pulse, P_DATA=8'h55.
//   4. PAR_EN=1, PAR_TYP=1, Prescale=16; send 8'hA3 with parity 1 -> P_DATA=8'hA3.
//      Then send 8'hA3 with stop bit 0 -> no data_valid.
//   5. RX_IN low pulse of 2 CLKs while idle -> glitch rejected, FSM returns to IDLE,
//      no data_valid.
//      Single-CLK flips at one of the 3 sample points inside a data bit
//      -> byte still correct.
//   6. Assert RST mid-DATA -> P_DATA=0 and data_valid=0 next edge.
//      A following clean frame 8'h3C -> P_DATA=8'h3C.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and constants for the UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sampler
// Purpose  : Per-bit edge counter and 3-point majority vote around mid-bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    input  logic       i_clear,
    input  logic [4:0] i_prescale,
    output logic       o_bit,
    output logic       o_bit_valid,
    output logic       o_bit_end
);

    logic [4:0] r_edge_cnt;
    logic [2:0] r_samples;
    logic [4:0] w_half;

    assign w_half      = i_prescale >> 1;
    assign o_bit_end   = (r_edge_cnt == i_prescale - 5'd1);
    assign o_bit_valid = (r_edge_cnt >= w_half + 5'd2);
    assign o_bit       = (r_samples[0] & r_samples[1]) |
                         (r_samples[0] & r_samples[2]) |
                         (r_samples[1] & r_samples[2]);

    // Counter is 5 bits wide, so even an illegal prescale wraps and never stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_edge_cnt <= 5'd0;
            r_samples  <= 3'b000;
        end else begin
            if (i_clear || o_bit_end)
                r_edge_cnt <= 5'd0;
            else
                r_edge_cnt <= r_edge_cnt + 5'd1;

            if (r_edge_cnt == w_half - 5'd1) r_samples[0] <= i_rx;
            if (r_edge_cnt == w_half)        r_samples[1] <= i_rx;
            if (r_edge_cnt == w_half + 5'd1) r_samples[2] <= i_rx;
        end
    end

endmodule : uart_rx_sampler
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Purpose  : Oversampling UART receiver, 8N1 / 8E1 / 8O1, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [4:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid
);

    localparam int CW = $clog2(DATA_WIDTH);

    rx_state_t             r_state, w_next;
    logic [4:0]            r_prescale;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    logic w_bit, w_bit_valid, w_bit_end;
    logic w_start_det, w_frame_ok, w_par_exp;

    uart_rx_sampler u_sampler (
        .clk         (CLK),
        .rst         (RST),
        .i_rx        (RX_IN),
        .i_clear     (r_state == ST_IDLE),
        .i_prescale  (r_prescale),
        .o_bit       (w_bit),
        .o_bit_valid (w_bit_valid),
        .o_bit_end   (w_bit_end)
    );

    assign w_par_exp  = (r_par_typ == PAR_ODD) ? ~^r_shift : ^r_shift;
    assign P_DATA     = r_p_data;
    assign data_valid = r_data_valid;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start_det = 1'b0;
        w_frame_ok  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!RX_IN) begin
                    w_next      = ST_START;
                    w_start_det = 1'b1;
                end
            end
            ST_START: begin
                if (w_bit_end) w_next = w_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end && (r_bit_cnt == CW'(DATA_WIDTH - 1)))
                    w_next = r_par_en ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (w_bit_end) w_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    // Include a low stop sample seen on this very cycle.
                    w_frame_ok = !r_par_err && !r_stp_err && !(w_bit_valid && !w_bit);
                    if (!RX_IN) begin
                        w_next      = ST_START;
                        w_start_det = 1'b1;
                    end else begin
                        w_next = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prescale   <= 5'd0;
            r_par_en     <= 1'b0;
            r_par_typ    <= PAR_EVEN;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_p_data     <= '0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            if (r_state == ST_DATA && w_bit_end) begin
                r_shift   <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (r_state == ST_PARITY && w_bit_valid && (w_bit != w_par_exp))
                r_par_err <= 1'b1;
            if (r_state == ST_STOP && w_bit_valid && !w_bit)
                r_stp_err <= 1'b1;
            if (w_frame_ok) begin
                r_p_data     <= r_shift;
                r_data_valid <= 1'b1;
            end
            // A new start wins over any flag set on the same edge.
            if (w_start_det) begin
                r_prescale <= Prescale;
                r_par_en   <= PAR_EN;
                r_par_typ  <= PAR_TYP;
                r_bit_cnt  <= '0;
                r_par_err  <= 1'b0;
                r_stp_err  <= 1'b0;
            end
        end
    end

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Scoreboard bench for uart_rx: expected bytes queued per frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [4:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] r_exp_b;
    logic [7:0] c_flip_bytes [3] = '{8'h96, 8'h5A, 8'hE1};

    uart_rx dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(data_valid), 32'd0);
            end else begin
                r_exp_b = exp_q.pop_front();
                check("p_data", 32'(P_DATA), 32'(r_exp_b));
            end
        end
    end

    task automatic drive_bit(input logic b, input int p, input int flip);
        for (int c = 0; c < p; c++) begin
            RX_IN = (c == flip) ? ~b : b;
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_en, input logic par_bit,
                              input logic stop_bit, input int p, input int flip);
        drive_bit(1'b0, p, -1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p, flip);
        if (par_en) drive_bit(par_bit, p, -1);
        drive_bit(stop_bit, p, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RX_IN = 1'b1; RST = 1'b1; Prescale = 5'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_p_data", 32'(P_DATA), 32'h00);
        check("reset_valid", 32'(data_valid), 32'd0);
        RST = 1'b0;
        idle(10);

        // 8'h55 with even parity, then 8'h6D back-to-back with a bad parity bit
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0, 1'b1, 8, -1);
        send_frame(8'h6D, 1'b1, 1'b0, 1'b1, 8, -1);
        idle(24);
        check("hold_after_par_err", 32'(P_DATA), 32'h55);

        // 10-bit frame, no parity
        PAR_EN = 1'b0;
        idle(4);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 8, -1);
        idle(24);

        // Prescale 16, odd parity; then a framing error
        PAR_EN = 1'b1; PAR_TYP = 1'b1; Prescale = 5'd16;
        idle(4);
        exp_q.push_back(8'hA3);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1, 16, -1);
        idle(40);
        check("p_data_a3", 32'(P_DATA), 32'hA3);
        send_frame(8'hA3, 1'b1, 1'b1, 1'b0, 16, -1);
        idle(48);
        check("hold_after_stp_err", 32'(P_DATA), 32'hA3);

        // Two-clock glitch on an idle line
        Prescale = 5'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        idle(4);
        RX_IN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        idle(30);
        check("hold_after_glitch", 32'(P_DATA), 32'hA3);

        // One-clock flips landing on each of the three mid-bit sample points
        for (int f = 4; f <= 6; f++) begin
            exp_q.push_back(c_flip_bytes[f-4]);
            send_frame(c_flip_bytes[f-4], 1'b0, 1'b0, 1'b1, 8, f);
            idle(16);
        end

        // Reset in the middle of the data bits
        drive_bit(1'b0, 8, -1);
        drive_bit(1'b1, 8, -1);
        drive_bit(1'b0, 8, -1);
        drive_bit(1'b1, 3, -1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("midreset_p_data", 32'(P_DATA), 32'h00);
        check("midreset_valid", 32'(data_valid), 32'd0);
        RST = 1'b0;
        idle(30);
        check("idle_after_reset", 32'(P_DATA), 32'h00);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 8, -1);
        idle(24);
        check("p_data_3c", 32'(P_DATA), 32'h3C);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
